// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU write-back slice of the 4-bit datapath.
// Holds control-word bit positions, FSM state encoding and width defaults.
package alu_writeback_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_W_DEF  = 4;
  localparam int CTRL_W     = 16;

  // Control word bit positions. Only the WR_* bits matter to write-back;
  // the select/accumulate bits belong to the operand path upstream.
  localparam int CTRL_SEL_A    = 3;
  localparam int CTRL_SEL_B    = 4;
  localparam int CTRL_ACC_NZ_A = 7;
  localparam int CTRL_WR_A     = 8;
  localparam int CTRL_WR_B     = 9;
  localparam int CTRL_WR_FLAGS = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/alu_wb_flag_gen.sv
// Status flag decode for a committed ALU result.
//   data_i : full-width ALU result
//   zero_o : result is zero across all DATA_W bits
//   ovf_o  : result has bits above REG_W set (lost by truncation)
module alu_wb_flag_gen #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              zero_o,
  output logic              ovf_o
);

  assign zero_o = (data_i == '0);
  assign ovf_o  = |data_i[DATA_W-1:REG_W];

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back unit: accepts an ALU result over valid/ready, narrows it to
// REG_W bits and commits it to Register A and/or B, and updates status flags.
// Two-state FSM (IDLE -> COMMIT -> IDLE), so at most one result per 2 cycles.
//
// Optional feature macro: ALU_WB_FLAGS_EN compiles in flag_zero/flag_ovf
// logic; without it both flags are tied to 0 and WR_FLAGS is ignored.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   wb_valid/wb_ready : result handshake (transfer when both high at an edge)
//   wb_data           : ALU result, DATA_W bits
//   control           : 16-bit control word; bits 8/9/10 = WR_A/WR_B/WR_FLAGS
//   reg_a, reg_b      : architectural registers fed back to the ALU
//   flag_zero/ovf     : status from the last flag-writing result
//   wb_done           : one-cycle pulse during the commit cycle
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [CTRL_W-1:0] control,
  output logic [REG_W-1:0]  reg_a,
  output logic [REG_W-1:0]  reg_b,
  output logic              flag_zero,
  output logic              flag_ovf,
  output logic              wb_done
);

  wb_state_e         state_q;
  logic              ready_q;
  logic              done_q;
  logic [DATA_W-1:0] data_q;
  // wr_q[0]=WR_A, wr_q[1]=WR_B, wr_q[2]=WR_FLAGS
  logic [2:0]        wr_q;
  logic [REG_W-1:0]  reg_a_q;
  logic [REG_W-1:0]  reg_b_q;

  // Ready is a register rather than a state decode so it reads 0 for the
  // whole of reset and no input ever reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      wr_q    <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_valid && ready_q) begin
            data_q  <= wb_data;
            wr_q    <= control[CTRL_WR_FLAGS:CTRL_WR_A];
            state_q <= COMMIT;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        COMMIT: begin
          // Writes come only from the holding registers; live inputs are
          // ignored here so the producer may change them freely.
          if (wr_q[0]) reg_a_q <= data_q[REG_W-1:0];
          if (wr_q[1]) reg_b_q <= data_q[REG_W-1:0];
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic zero_d, ovf_d;
  logic zero_q, ovf_q;

  alu_wb_flag_gen #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_flag_gen (
    .data_i (data_q),
    .zero_o (zero_d),
    .ovf_o  (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == COMMIT && wr_q[2]) begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
`else
  // Upper result bits and WR_FLAGS only feed the flags.
  logic unused_flag_src;
  assign unused_flag_src = ^{data_q[DATA_W-1:REG_W], wr_q[2]};
  assign flag_zero = 1'b0;
  assign flag_ovf  = 1'b0;
`endif

  // Select/accumulate bits of the control word are consumed upstream.
  logic unused_ctrl;
  assign unused_ctrl = ^{control[CTRL_W-1:CTRL_WR_FLAGS+1], control[CTRL_WR_A-1:0]};

  assign wb_ready = ready_q;
  assign wb_done  = done_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [7:0]  wb_data;
  logic [15:0] control;
  logic [3:0]  reg_a, reg_b;
  logic        flag_zero, flag_ovf, wb_done;

  localparam logic [15:0] WR_A = 16'h0100;
  localparam logic [15:0] WR_B = 16'h0200;
  localparam logic [15:0] WR_F = 16'h0400;
`ifdef ALU_WB_FLAGS_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .control   (control),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .flag_zero (flag_zero),
    .flag_ovf  (flag_ovf),
    .wb_done   (wb_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transfer: wait (bounded) for ready, hand over, check the commit
  // pulse, then scribble on the inputs during COMMIT to prove they're ignored.
  task automatic xfer(input string tag, input logic [7:0] d, input logic [15:0] c);
    int n = 0;
    wb_valid = 1'b1;
    wb_data  = d;
    control  = c;
    while (!wb_ready && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) chk({tag, "_ready_timeout"}, 0, 1);
    tick();
    chk({tag, "_ready_commit"}, wb_ready, 0);
    chk({tag, "_done_commit"}, wb_done, 1);
    wb_valid = 1'b0;
    wb_data  = ~d;
    control  = 16'hFFFF;
    tick();
    chk({tag, "_done_after"}, wb_done, 0);
    chk({tag, "_ready_after"}, wb_ready, 1);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic z, input logic o);
    chk({tag, "_reg_a"}, reg_a, a);
    chk({tag, "_reg_b"}, reg_b, b);
    chk({tag, "_zero"}, flag_zero, z & FE);
    chk({tag, "_ovf"}, flag_ovf, o & FE);
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_data  = 8'h00;
    control  = 16'h0000;

    // Reset held two edges.
    @(posedge clk);
    tick();
    chk("rst_ready", wb_ready, 0);
    chk("rst_done", wb_done, 0);
    chk_state("rst", 4'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rel_ready", wb_ready, 1);
    chk("rel_done", wb_done, 0);

    // WR_A only; unrelated control bits set to show they are ignored.
    xfer("t3c", 8'h3C, WR_A | 16'h0098);
    chk_state("t3c", 4'hC, 4'h0, 1'b0, 1'b0);

    // WR_B | WR_FLAGS with upper bits set: truncation plus overflow.
    xfer("tf5", 8'hF5, WR_B | WR_F);
    chk_state("tf5", 4'hC, 4'h5, 1'b0, 1'b1);

    // Zero result to both registers with flags.
    xfer("t00", 8'h00, WR_A | WR_B | WR_F);
    chk_state("t00", 4'h0, 4'h0, 1'b1, 1'b0);

    // WR_A without WR_FLAGS: flags must hold.
    xfer("t13", 8'h13, WR_A);
    chk_state("t13", 4'h3, 4'h0, 1'b1, 1'b0);

    // No write bits: nothing changes but the transaction still completes.
    xfer("tnone", 8'h2A, 16'h0000);
    chk_state("tnone", 4'h3, 4'h0, 1'b1, 1'b0);

    // Flags rewritten by a non-zero in-range value.
    xfer("t09", 8'h09, WR_B | WR_F);
    chk_state("t09", 4'h3, 4'h9, 1'b0, 1'b0);

    // Streaming: valid held high, one transfer every other edge.
    pulses   = 0;
    wb_valid = 1'b1;
    wb_data  = 8'h01;
    control  = WR_A;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (wb_done) pulses++;
      chk($sformatf("strm_done_%0d", i), wb_done, ((i % 2) == 1) && (i <= 5));
      if ((i % 2) == 1) begin
        wb_data = 8'hEE;
      end else begin
        chk($sformatf("strm_reg_a_%0d", i), reg_a, (i >= 6) ? 3 : i / 2);
        if (i / 2 < 3) wb_data = 8'(i / 2 + 1);
        else wb_valid = 1'b0;
      end
    end
    chk("strm_pulses", pulses, 3);
    chk("strm_reg_b", reg_b, 4'h9);

    // Reset during COMMIT discards the pending write.
    wb_valid = 1'b1;
    wb_data  = 8'h07;
    control  = WR_A;
    tick();
    chk("rc_done_commit", wb_done, 1);
    reset    = 1'b1;
    wb_valid = 1'b0;
    tick();
    chk("rc_done", wb_done, 0);
    chk("rc_ready", wb_ready, 0);
    chk_state("rc", 4'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rc2_done", wb_done, 0);
    chk("rc2_ready", wb_ready, 1);
    chk("rc2_reg_a", reg_a, 4'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Write-back unit at the ALU output of the 4-bit microcontroller datapath. It accepts an 8-bit ALU result with a valid/ready handshake and the 16-bit control word. It narrows the result to 4 bits and commits it into Register A and/or Register B, and it updates the zero and overflow status flags. It owns the A/B register state and drives the register values back to the ALU operand-select path, closing the datapath loop.

## Interface
Parameters:
- DATA_W, 8: width of ALU result input.
- REG_W, 4: width of architectural registers A and B.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  ALU result and control word are valid this cycle.
- wb_ready  output  1  unit can accept a result this cycle.
- wb_data  input  DATA_W  ALU result.
- control  input  16  control word; bit 8 = WR_A, bit 9 = WR_B, bit 10 = WR_FLAGS; other bits ignored.
- reg_a  output  REG_W  current Register A value.
- reg_b  output  REG_W  current Register B value.
- flag_zero  output  1  last flag-writing result was zero.
- flag_ovf  output  1  last flag-writing result did not fit in REG_W bits.
- wb_done  output  1  single-cycle pulse, high in the commit cycle.

## Operation
- FSM states:
  - IDLE: wb_ready=1.
  - COMMIT: wb_ready=0, wb_done=1.
- Transitions:
  - IDLE→COMMIT on wb_valid && wb_ready. The transfer latches wb_data and control[10:8] into holding registers.
  - COMMIT→IDLE unconditionally.
- COMMIT writes from the holding registers only, never from the live inputs:
  - WR_A: reg_a ← data[REG_W-1:0].
  - WR_B: reg_b ← data[REG_W-1:0].
  - WR_A and WR_B both set: both registers take the same low nibble.
  - Neither set: no register write. The transaction still completes and wb_done still pulses.
  - WR_FLAGS: flag_zero ← (data[DATA_W-1:0] == 0); flag_ovf ← |data[DATA_W-1:REG_W].
  - WR_FLAGS clear: both flags hold.
- Truncation: the upper DATA_W-REG_W bits are never stored in A or B. They only reach the status flags through flag_ovf.
- Inputs while in COMMIT: wb_valid is ignored and wb_data/control changes have no effect. The producer holds its data until it sees wb_ready.
- Control word bits other than 8–10 have no effect on this block.

## Timing
- Reset values: state IDLE, reg_a=0, reg_b=0, flag_zero=0, flag_ovf=0, wb_done=0, holding registers 0.
- wb_ready is 0 in any cycle where reset=1, and 1 in the first cycle after reset deasserts.
- Latency:
  - Handshake at edge N: state=COMMIT and wb_done=1 between edge N and edge N+1.
  - reg_a, reg_b and the flags show the new values after edge N+1.
- Throughput: one result per 2 cycles. With wb_valid held high continuously, a transfer occurs at every other edge and no result is dropped.
- Reset during COMMIT: reset takes priority. The pending write is discarded, all state goes to reset values, and no further wb_done is produced for that transaction.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Configuration
- ALU_WB_FLAGS_EN defined:
  - Flag logic and flag registers are compiled in.
  - WR_FLAGS behaves as described in Operation.
- ALU_WB_FLAGS_EN undefined:
  - Flag registers are removed.
  - flag_zero and flag_ovf are tied to 0.
  - WR_FLAGS is ignored.
  - Register write-back and handshake behaviour are unchanged.

## Structure
- Shared package holds:
  - The control word bit-index constants: CTRL_SEL_A=3, CTRL_SEL_B=4, CTRL_ACC_NZ_A=7, CTRL_WR_A=8, CTRL_WR_B=9, CTRL_WR_FLAGS=10.
  - The FSM state encoding (IDLE, COMMIT).
  - REG_W/DATA_W defaults.
- One sub-module, alu_wb_flag_gen: combinational, data in → zero/ovf out. It is instantiated only under ALU_WB_FLAGS_EN.

## Test plan
- Reset: hold reset 2 cycles → reg_a=0, reg_b=0, flags 0, wb_done=0, wb_ready=0 during reset and 1 on the first cycle after release.
- wb_data=8'h3C, WR_A → wb_ready=0 and wb_done=1 for exactly one cycle; after 2 edges reg_a=4'hC, reg_b=0, flags unchanged.
- wb_data=8'hF5, WR_B|WR_FLAGS → reg_b=4'h5, flag_ovf=1, flag_zero=0, reg_a unchanged.
- wb_data=8'h00, WR_A|WR_B|WR_FLAGS → reg_a=reg_b=0, flag_zero=1, flag_ovf=0. Repeat without ALU_WB_FLAGS_EN → both flags stay 0.
- wb_valid held high with wb_data 8'h01, 8'h02, 8'h03 (each held until accepted), WR_A → exactly three wb_done pulses 2 cycles apart, reg_a sequence 1,2,3. Changing wb_data during COMMIT has no effect.
- Handshake wb_data=8'h07, WR_A, then reset=1 in the COMMIT cycle → reg_a=0 and no wb_done on the following cycle.
